sfu_accum_pool: RTL
===================

// Module: sfu_accum_pool
// PURPOSE
// Parametrised special-function unit sitting between the OFIFO and the PSUM SRAM. Accumulates
// per-kernel-index partial sums over all kij passes, remapping each streamed input position
// nij to its output position onij. On request, reads back the accumulated map and emits
// per-lane ReLU + 2x2 pooled vectors (max or average), with saturating or wrapping accumulation.
// PARAMETERS
// psum_bw   16  signed per-lane partial-sum width
// col       8   lanes per vector (vector width = psum_bw*col)
// in_dim    6   input feature-map side; in_dim*in_dim vectors streamed per kij pass
// ker       3   kernel side; kij in [0, ker*ker-1]; out_dim = in_dim-ker+1 (must be even)
// a_bw      4   PSUM address width, >= clog2(out_dim*out_dim)
// sat_en    0   1: per-lane saturating add; 0: two's-complement wrap
// PORTS
// clk            in   1             rising-edge clock
// reset          in   1             synchronous, active-high
// kij            in   4             current kernel index; stable for a whole pass
// ofifo_valid    in   1             psum vector present this cycle
// ofifo_data     in   psum_bw*col   psum vector, lane i at [psum_bw*i +: psum_bw]
// Q_pmem         in   psum_bw*col   PSUM SRAM read data (1-cycle read latency)
// ren_pmem       out  1             PSUM SRAM read enable
// r_A_pmem       out  a_bw          PSUM SRAM read address
// wen_pmem       out  1             PSUM SRAM write enable
// w_A_pmem       out  a_bw          PSUM SRAM write address
// D_pmem         out  psum_bw*col   PSUM SRAM write data
// relu_en        in   1             apply ReLU before pooling (sampled at readout_start)
// pool_avg       in   1             0: 2x2 max pool; 1: 2x2 average (sampled at readout_start)
// readout_start  in   1             one-cycle pulse; starts readout when IDLE
// readout        out  psum_bw*col   pooled vector
// readout_valid  out  1             readout holds a valid pooled vector this cycle
// busy           out  1             high in any state other than IDLE
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; nij counter 0; reset mid-pass/readout aborts cleanly, no write.
// - States: IDLE -> ACCUM on ofifo_valid; ACCUM -> IDLE one cycle after last beat drains;
//   IDLE -> RDOUT on readout_start; RDOUT -> IDLE after final window. readout_start outside IDLE and
//   ofifo_valid in RDOUT are ignored.
// - Mapping: nij=(r,c) row-major counter, kij=(kr,kc)=(kij/ker, kij%ker); o_r=r-kr, o_c=c-kc;
//   beat valid iff 0<=o_r,o_c<out_dim; onij=o_r*out_dim+o_c. Invalid beats: no SRAM access.
//   nij increments on every ofifo_valid, wraps in_dim*in_dim-1 -> 0 (pass complete).
// - Accumulate pipeline, cycle t (valid beat): kij!=0 -> ren_pmem=1, r_A_pmem=onij; data and onij
//   registered. Cycle t+1: wen_pmem=1, w_A_pmem=onij, D_pmem = kij==0 ? data : Q_pmem+data per lane.
//   Write latency 1 for both cases. Back-to-back beats always hit distinct onij: no forwarding.
// - Arithmetic: lanes signed; sat_en=1 clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
// - Readout: windows w=0..(out_dim/2)^2-1 row-major; each reads 4 addresses (top-left, top-right,
//   bottom-left, bottom-right) in 4 consecutive cycles; lane value v = relu_en ? max(v,0) : v;
//   max mode keeps running max; avg mode sums in psum_bw+2 bits then arithmetic >>>2 (floor).
//   readout_valid pulses 1 cycle, 1 cycle after last read's data returns (window period 5 cycles);
//   readout holds value until next window. wen_pmem=0 throughout readout.
// TESTING
// - Single pass kij=0, 36 beats, lane data = nij -> 16 writes, addr onij gets value r*6+c, D equals data.
// - kij=4 after kij=0 with all-ones data -> writes only for r,c in 1..4; each onij holds 2.
// - Full 9-pass golden psum_kij0..8 stream + readout_start, relu_en=1, pool_avg=0 -> 4 windows match out.txt.
// - Lane values {-8,2,6,-4} in a window: max/relu -> 6; avg/no-relu -> -1 (floor of -4/4); avg/relu -> 2.
// - sat_en=1, accumulate 0x7FF0 + 0x0020 -> 0x7FFF; sat_en=0 -> 0x8010.
// - reset asserted mid-pass (beat 20) -> next cycle wen/ren/busy=0; fresh pass restarts at nij=0.

Source files
------------

// File: rtl/sfu_accum_pool.sv
// Accumulates per-kij partial-sum vectors into the PSUM SRAM (output-position remapped) and
// reads the accumulated map back as ReLU + 2x2 max/average pooled vectors.
module sfu_accum_pool #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int in_dim  = 6,
  parameter int ker     = 3,
  parameter int a_bw    = 4,
  parameter int sat_en  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             kij,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_data,
  input  logic [psum_bw*col-1:0] Q_pmem,
  output logic                   ren_pmem,
  output logic [a_bw-1:0]        r_A_pmem,
  output logic                   wen_pmem,
  output logic [a_bw-1:0]        w_A_pmem,
  output logic [psum_bw*col-1:0] D_pmem,
  input  logic                   relu_en,
  input  logic                   pool_avg,
  input  logic                   readout_start,
  output logic [psum_bw*col-1:0] readout,
  output logic                   readout_valid,
  output logic                   busy
);

  localparam int OUT_DIM = in_dim - ker + 1;
  localparam int HALF    = OUT_DIM / 2;
  localparam int RC_W    = (in_dim > 1) ? $clog2(in_dim) : 1;
  localparam int HW_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int AW      = psum_bw + 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RDOUT} state_t;

  state_t                 r_state, w_next;
  logic [RC_W-1:0]        r_row, r_col;
  logic                   r_pend, r_first;
  logic [a_bw-1:0]        r_waddr;
  logic [psum_bw*col-1:0] r_data;
  logic [2:0]             r_phase;
  logic [HW_W-1:0]        r_wr, r_wc;
  logic                   r_relu, r_avg;
  logic signed [AW-1:0]   r_acc [col];
  logic [psum_bw*col-1:0] r_readout;
  logic                   r_valid;

  logic                   w_beat, w_hit, w_rd, w_lastWin;
  int                     w_or, w_oc;
  logic [a_bw-1:0]        w_onij, w_rdaddr;
  logic signed [AW-1:0]   w_v [col];
  logic signed [AW-1:0]   w_comb [col];
  logic [psum_bw*col-1:0] w_final;

  // One-extra-bit sum; overflow shows as the top two bits disagreeing.
  function automatic logic [psum_bw-1:0] addLane(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (sat_en != 0 && s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s[psum_bw-1:0];
  endfunction

  always_comb begin
    w_beat    = ofifo_valid && (r_state != S_RDOUT) && !reset;
    w_or      = int'(r_row) - int'(kij) / ker;
    w_oc      = int'(r_col) - int'(kij) % ker;
    w_hit     = w_beat && (w_or >= 0) && (w_or < OUT_DIM) && (w_oc >= 0) && (w_oc < OUT_DIM);
    w_onij    = a_bw'(w_or * OUT_DIM + w_oc);
    w_rd      = (r_state == S_RDOUT) && (r_phase < 3'd4) && !reset;
    w_rdaddr  = a_bw'((2 * int'(r_wr) + int'(r_phase[1])) * OUT_DIM
                      + 2 * int'(r_wc) + int'(r_phase[0]));
    w_lastWin = (r_wr == HW_W'(HALF - 1)) && (r_wc == HW_W'(HALF - 1));
  end

  always_comb begin
    ren_pmem = w_rd || (w_hit && kij != 4'd0);
    r_A_pmem = '0;
    if (w_rd)
      r_A_pmem = w_rdaddr;
    else if (w_hit && kij != 4'd0)
      r_A_pmem = w_onij;
    wen_pmem = r_pend && !reset;
    w_A_pmem = wen_pmem ? r_waddr : '0;
    D_pmem   = '0;
    if (wen_pmem)
      for (int i = 0; i < col; i++)
        D_pmem[i*psum_bw +: psum_bw] = r_first ? r_data[i*psum_bw +: psum_bw]
                                      : addLane(Q_pmem[i*psum_bw +: psum_bw],
                                                r_data[i*psum_bw +: psum_bw]);
  end

  // Pooling datapath works in psum_bw+2 bits so a four-term sum cannot overflow.
  always_comb begin
    w_final = '0;
    for (int i = 0; i < col; i++) begin
      w_v[i] = {{2{Q_pmem[i*psum_bw + psum_bw - 1]}}, Q_pmem[i*psum_bw +: psum_bw]};
      if (r_relu && w_v[i] < 0)
        w_v[i] = '0;
      if (r_avg)
        w_comb[i] = r_acc[i] + w_v[i];
      else
        w_comb[i] = (w_v[i] > r_acc[i]) ? w_v[i] : r_acc[i];
      w_final[i*psum_bw +: psum_bw] = r_avg ? psum_bw'(w_comb[i] >>> 2) : psum_bw'(w_comb[i]);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ofifo_valid) w_next = S_ACCUM;
               else if (readout_start) w_next = S_RDOUT;
      S_ACCUM: if (!ofifo_valid && !r_pend) w_next = S_IDLE;
      S_RDOUT: if (r_phase == 3'd4 && w_lastWin) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= '0;
      r_col   <= '0;
      r_pend  <= 1'b0;
      r_first <= 1'b0;
      r_waddr <= '0;
      r_data  <= '0;
    end else begin
      r_pend  <= w_hit;
      r_first <= (kij == 4'd0);
      r_waddr <= w_onij;
      r_data  <= ofifo_data;
      if (w_beat) begin
        if (r_col == RC_W'(in_dim - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RC_W'(in_dim - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Phases 0-3 issue reads; phases 1-4 fold the returning data; phase 4 publishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= '0;
      r_wr      <= '0;
      r_wc      <= '0;
      r_relu    <= 1'b0;
      r_avg     <= 1'b0;
      r_readout <= '0;
      r_valid   <= 1'b0;
      for (int i = 0; i < col; i++) r_acc[i] <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_IDLE && w_next == S_RDOUT) begin
        r_relu  <= relu_en;
        r_avg   <= pool_avg;
        r_phase <= '0;
        r_wr    <= '0;
        r_wc    <= '0;
      end else if (r_state == S_RDOUT) begin
        for (int i = 0; i < col; i++)
          r_acc[i] <= (r_phase == 3'd1) ? w_v[i] : w_comb[i];
        if (r_phase == 3'd4) begin
          r_phase   <= '0;
          r_valid   <= 1'b1;
          r_readout <= w_final;
          if (r_wc == HW_W'(HALF - 1)) begin
            r_wc <= '0;
            r_wr <= r_wr + 1'b1;
          end else begin
            r_wc <= r_wc + 1'b1;
          end
        end else begin
          r_phase <= r_phase + 1'b1;
        end
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign readout       = r_readout;
  assign readout_valid = r_valid;

endmodule
